// File: rtl/cgra_issue_if.sv
// cgra_issue_if: instruction-memory, decoder and vector-datapath signals of the issue controller
interface cgra_issue_if #(
  parameter int DWIDTH_INST = 32,
  parameter int IMEM_AW = 8
);
  logic imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [DWIDTH_INST-1:0] imem_rdata;
  logic [DWIDTH_INST-1:0] instr;
  logic instr_valid;
  logic dec_is_not_vect;
  logic dec_is_bne;
  logic dec_is_wfi;
  logic [11:0] dec_branch_imm;
  logic bne_taken;
  logic vec_issue;
  logic vec_done;
  modport master (
    output imem_en, imem_addr, instr, instr_valid, vec_issue,
    input imem_rdata, dec_is_not_vect, dec_is_bne, dec_is_wfi, dec_branch_imm, bne_taken, vec_done
  );
  modport slave (
    input imem_en, imem_addr, instr, instr_valid, vec_issue,
    output imem_rdata, dec_is_not_vect, dec_is_bne, dec_is_wfi, dec_branch_imm, bne_taken, vec_done
  );
endinterface

// File: rtl/cgra_issue_ctrl.sv
// cgra_issue_ctrl: fetch/issue sequencer for the CGRA vector core; define CGRA_ISSUE_TIMEOUT_EN to build the VWAIT watchdog
module cgra_issue_ctrl #(
  parameter int DWIDTH_INST = 32,
  parameter int IMEM_AW = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  cgra_issue_if.master bus,
  output logic [IMEM_AW-1:0] pc,
  output logic busy,
  output logic halted,
  output logic err
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, VWAIT, HALT} state_t;
  state_t state;
  logic signed [11:0] off;
  logic [IMEM_AW-1:0] pc_exec;
  logic timeout;
  assign off = $signed(bus.dec_branch_imm) >>> 1;
  assign pc_exec = (bus.dec_is_bne && bus.bne_taken) ? pc + IMEM_AW'(off) : pc + IMEM_AW'(1);
  assign bus.imem_addr = pc;
  assign bus.vec_issue = bus.instr_valid && !bus.dec_is_wfi && !bus.dec_is_not_vect;
`ifdef CGRA_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt;
  // watchdog counts VWAIT cycles and restarts from zero whenever the FSM is elsewhere
  always_ff @(posedge clk) wcnt <= (rst || state != VWAIT) ? '0 : wcnt + CW'(1);
  assign timeout = wcnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  // sequencer FSM; strobes and status flags are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      bus.instr <= '0;
      bus.imem_en <= 1'b0;
      bus.instr_valid <= 1'b0;
      busy <= 1'b0;
      halted <= 1'b0;
      err <= 1'b0;
    end else begin
      bus.imem_en <= 1'b0;
      bus.instr_valid <= 1'b0;
      case (state)
        IDLE, HALT: if (start) begin
          state <= FETCH;
          pc <= '0;
          bus.imem_en <= 1'b1;
          busy <= 1'b1;
          halted <= 1'b0;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          state <= EXEC;
          bus.instr <= DWIDTH_INST'(bus.imem_rdata);
          bus.instr_valid <= 1'b1;
        end
        EXEC: if (bus.dec_is_wfi) begin
          state <= HALT;
          busy <= 1'b0;
          halted <= 1'b1;
        end else if (!bus.dec_is_not_vect) begin
          state <= VWAIT;
        end else begin
          state <= FETCH;
          pc <= pc_exec;
          bus.imem_en <= 1'b1;
        end
        VWAIT: if (bus.vec_done) begin
          state <= FETCH;
          pc <= pc + IMEM_AW'(1);
          bus.imem_en <= 1'b1;
        end else if (timeout) begin
          state <= HALT;
          busy <= 1'b0;
          halted <= 1'b1;
          err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cgra_issue_ctrl.sv
// tb_cgra_issue_ctrl: directed vectors plus random programs against an instruction-level model
module tb_cgra_issue_ctrl;
  typedef struct {
    int addr;
    logic [31:0] word;
    int exp_next;
    string name;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] pc;
  logic busy, halted, err;
  logic [31:0] mem [256];
  logic [31:0] rdata_q;
  int checks = 0;
  int failures = 0;
  cgra_issue_if #(.DWIDTH_INST(32), .IMEM_AW(8)) bus ();
  cgra_issue_ctrl #(.DWIDTH_INST(32), .IMEM_AW(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .pc(pc), .busy(busy), .halted(halted), .err(err)
  );
  always #5 clk = ~clk;
  // instruction memory with one cycle read latency
  always @(posedge clk) if (bus.imem_en) rdata_q <= mem[bus.imem_addr];
  assign bus.imem_rdata = rdata_q;
  // toy ISA: [31:30] op (0 addi, 1 vector, 2 bne, 3 wfi), [12] compare result, [11:0] branch imm
  assign bus.dec_is_wfi = bus.instr[31:30] == 2'd3;
  assign bus.dec_is_not_vect = bus.instr[31:30] != 2'd1;
  assign bus.dec_is_bne = bus.instr[31:30] == 2'd2;
  assign bus.dec_branch_imm = bus.instr[11:0];
  assign bus.bne_taken = bus.instr[12];

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [11:0] imm, input logic t);
    return {op, 17'd0, t, imm};
  endfunction

  function automatic int br_target(input int p, input logic [11:0] imm);
    int s = (imm >= 12'd2048) ? int'(imm) - 4096 : int'(imm);
    int o = (s - (s & 1)) / 2;
    return ((p + o) % 256 + 256) % 256;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string t);
    check({t, "_imem_en"}, 32'(bus.imem_en), 0);
    check({t, "_instr_valid"}, 32'(bus.instr_valid), 0);
    check({t, "_vec_issue"}, 32'(bus.vec_issue), 0);
    check({t, "_busy"}, 32'(busy), 0);
    check({t, "_halted"}, 32'(halted), 0);
    check({t, "_err"}, 32'(err), 0);
    check({t, "_pc"}, 32'(pc), 0);
    check({t, "_instr"}, bus.instr, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.vec_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_addi();
    for (int a = 0; a < 256; a++) mem[a] = mk(2'd0, 12'd0, 1'b0);
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vec_t tv[9];
    int vq[$], fq[$], ea[$], eg[$], lq[$], oa[$], oc[$];
    int ic, issues, busy_low, seen, nxt, done_at, li, budget, mpc, lat, r;
    bit waiting, mhalt;
    logic [1:0] op;
    tv[0] = '{5, mk(2'd2, 12'hFFC, 1'b1), 3, "bne_back_taken"};
    tv[1] = '{5, mk(2'd2, 12'hFFC, 1'b0), 6, "bne_back_not_taken"};
    tv[2] = '{255, mk(2'd0, 12'h000, 1'b0), 0, "pc_wrap"};
    tv[3] = '{7, mk(2'd2, 12'h010, 1'b1), 15, "bne_fwd"};
    tv[4] = '{2, mk(2'd2, 12'h7FE, 1'b1), 1, "bne_max_pos_wrap"};
    tv[5] = '{10, mk(2'd2, 12'hF00, 1'b1), 138, "bne_neg_wrap"};
    tv[6] = '{4, mk(2'd0, 12'h010, 1'b1), 5, "addi_ignores_taken"};
    tv[7] = '{9, mk(2'd2, 12'h003, 1'b1), 10, "bne_odd_pos"};
    tv[8] = '{9, mk(2'd2, 12'hFFF, 1'b1), 8, "bne_odd_neg"};

    do_reset();
    check_idle("reset");

    // addi, addi, wfi: fetch 0,1,2 and instr_valid in cycles 3,6,9
    fill_addi();
    mem[2] = mk(2'd3, 12'd0, 1'b0);
    start_run();
    vq = {};
    fq = {};
    for (int c = 1; c <= 12; c++) begin
      if (bus.instr_valid) vq.push_back(c);
      if (bus.imem_en) fq.push_back(int'(bus.imem_addr));
      @(negedge clk);
    end
    check("valid_count", vq.size(), 3);
    check("fetch_count", fq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("valid_cycle", (i < vq.size()) ? vq[i] : -1, 3 * i + 3);
      check("fetch_addr", (i < fq.size()) ? fq[i] : -1, i);
    end
    check("wfi_halted", 32'(halted), 1);
    check("wfi_pc", 32'(pc), 2);
    check("wfi_busy", 32'(busy), 0);
    check("wfi_err", 32'(err), 0);

    // restart from HALT, with start pulses while busy being ignored
    start_run();
    fq = {};
    for (int c = 1; c <= 12; c++) begin
      if (bus.imem_en) fq.push_back(int'(bus.imem_addr));
      if (c == 1) check("halt_restart_busy", 32'(busy), 1);
      start = (c == 3 || c == 5 || c == 7);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_count", fq.size(), 3);
    for (int i = 0; i < 3; i++) check("busy_start_addr", (i < fq.size()) ? fq[i] : -1, i);
    check("busy_start_halted", 32'(halted), 1);

    // vector op: done pulse in EXEC ignored, real done 10 cycles after issue
    do_reset();
    fill_addi();
    mem[0] = mk(2'd1, 12'd0, 1'b0);
    mem[1] = mk(2'd3, 12'd0, 1'b0);
    start_run();
    ic = -1;
    issues = 0;
    busy_low = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.vec_issue) begin
        issues++;
        if (ic < 0) ic = c;
      end
      if (!busy && (ic < 0 || c <= ic + 11)) busy_low++;
      if (ic >= 0 && c == ic + 2) check("exec_done_ignored", 32'(busy && !bus.imem_en && !halted), 1);
      if (ic >= 0 && c == ic + 10) check("vwait_no_fetch", 32'(bus.imem_en), 0);
      if (ic >= 0 && c == ic + 11) begin
        check("post_vec_fetch_en", 32'(bus.imem_en), 1);
        check("post_vec_fetch_addr", 32'(bus.imem_addr), 1);
      end
      bus.vec_done = (ic >= 0) && (c == ic || c == ic + 10);
      @(negedge clk);
    end
    bus.vec_done = 1'b0;
    check("vec_issue_cycle", ic, 3);
    check("vec_issue_count", issues, 1);
    check("vec_busy_low", busy_low, 0);
    check("vec_end_halted", 32'(halted), 1);
    check("vec_end_pc", 32'(pc), 1);

    // reset while in VWAIT, with start and vec_done also asserted
    do_reset();
    fill_addi();
    mem[0] = mk(2'd1, 12'd0, 1'b0);
    start_run();
    repeat (6) @(negedge clk);
    check("vwait_busy", 32'(busy), 1);
    rst = 1'b1;
    start = 1'b1;
    bus.vec_done = 1'b1;
    @(negedge clk);
    check_idle("rst_vwait");
    rst = 1'b0;
    bus.vec_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("restart_en", 32'(bus.imem_en), 1);
    check("restart_addr", 32'(bus.imem_addr), 0);
    repeat (2) @(negedge clk);
    check("restart_vec_issue", 32'(bus.vec_issue), 1);

    // vec_done never arrives
    do_reset();
    fill_addi();
    mem[0] = mk(2'd1, 12'd0, 1'b0);
    start_run();
    for (int c = 1; c <= 30; c++) begin
`ifdef CGRA_ISSUE_TIMEOUT_EN
      if (c == 19) check("timeout_not_early", 32'(halted), 0);
      if (c == 20) begin
        check("timeout_halted", 32'(halted), 1);
        check("timeout_err", 32'(err), 1);
        check("timeout_pc", 32'(pc), 0);
        check("timeout_busy", 32'(busy), 0);
      end
`else
      if (c == 30) begin
        check("nowdog_busy", 32'(busy), 1);
        check("nowdog_halted", 32'(halted), 0);
        check("nowdog_err", 32'(err), 0);
      end
`endif
      @(negedge clk);
    end

    // table: next fetch address after executing one instruction at a given address
    foreach (tv[i]) begin
      do_reset();
      fill_addi();
      mem[tv[i].addr] = tv[i].word;
      start_run();
      seen = 0;
      nxt = -1;
      for (int c = 1; c < 1200 && nxt < 0; c++) begin
        if (bus.imem_en) begin
          if (seen != 0) nxt = int'(bus.imem_addr);
          else if (int'(bus.imem_addr) == tv[i].addr) seen = 1;
        end
        @(negedge clk);
      end
      check(tv[i].name, nxt, tv[i].exp_next);
    end

    // random programs against an instruction-level model
    for (int p = 0; p < 8; p++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 99);
        op = (r < 40) ? 2'd0 : (r < 55) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
        mem[a] = mk(op, 12'($urandom), 1'($urandom));
      end
      ea = {};
      eg = {};
      lq = {};
      mpc = 0;
      mhalt = 0;
      for (int s = 0; s < 30 && !mhalt; s++) begin
        ea.push_back(mpc);
        op = mem[mpc][31:30];
        if (op == 2'd3) mhalt = 1;
        else if (op == 2'd1) begin
          lat = $urandom_range(1, 12);
          lq.push_back(lat);
          eg.push_back(3 + lat);
          mpc = (mpc + 1) % 256;
        end else begin
          mpc = (op == 2'd2 && mem[mpc][12]) ? br_target(mpc, mem[mpc][11:0]) : (mpc + 1) % 256;
          eg.push_back(3);
        end
      end
      budget = 12;
      foreach (eg[i]) budget += eg[i];
      start_run();
      oa = {};
      oc = {};
      waiting = 0;
      done_at = 0;
      li = 0;
      for (int c = 1; c <= budget; c++) begin
        if (bus.imem_en && oa.size() < ea.size()) begin
          oa.push_back(int'(bus.imem_addr));
          oc.push_back(c);
        end
        bus.vec_done = waiting ? (c == done_at) : ($urandom_range(0, 3) == 0);
        if (waiting && c == done_at) waiting = 0;
        if (bus.vec_issue) begin
          waiting = 1;
          done_at = c + ((li < lq.size()) ? lq[li] : 1);
          li++;
        end
        @(negedge clk);
      end
      bus.vec_done = 1'b0;
      check("rand_fetch_count", oa.size(), ea.size());
      check("rand_first_cycle", (oc.size() > 0) ? oc[0] : -1, 1);
      for (int i = 0; i < ea.size(); i++) begin
        check("rand_fetch_addr", (i < oa.size()) ? oa[i] : -1, ea[i]);
        if (i > 0) check("rand_gap", (i < oc.size()) ? oc[i] - oc[i-1] : -1, eg[i-1]);
      end
      if (mhalt) begin
        check("rand_halted", 32'(halted), 1);
        check("rand_halt_pc", 32'(pc), ea[ea.size()-1]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cgra_issue_ctrl.md
Name: cgra_issue_ctrl

Overview:
- Instruction fetch/issue sequencer for the CGRA vector core.
- Fetches 32-bit instructions from a word-addressed instruction memory with 1-cycle read latency and presents each one to the ISA decoder.
- Steps the PC, resolves BNE branches, and stalls on vector instructions until the datapath reports completion.
- Halts on WFI and reports run status to the host control logic.

Parameters:
- DWIDTH_INST, 32, instruction width.
- IMEM_AW, 8, instruction memory word-address width; PC width.
- TIMEOUT_CYCLES, 1024, vector-wait watchdog limit (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin execution at PC 0; honoured only in IDLE or HALT
- imem_en  output  1  instruction memory read enable
- imem_addr  output  IMEM_AW  instruction memory word address
- imem_rdata  input  DWIDTH_INST  read data, valid the cycle after imem_en
- instr  output  DWIDTH_INST  registered instruction driven to the decoder
- instr_valid  output  1  instr is live for execution this cycle
- dec_is_not_vect  input  1  decoder: current instr is not a vector op
- dec_is_bne  input  1  decoder: current instr is BNE
- dec_is_wfi  input  1  decoder: current instr is WFI
- dec_branch_imm  input  12  decoder branch immediate
- bne_taken  input  1  scalar compare result (rs1 != rs2)
- vec_issue  output  1  one-cycle pulse: vector instr launched to datapath
- vec_done  input  1  datapath finished the current vector instr
- pc  output  IMEM_AW  current program counter
- busy  output  1  high in FETCH/LATCH/EXEC/VWAIT
- halted  output  1  high in HALT
- err  output  1  sticky watchdog error (0 when the optional feature is off)

Behaviour:
- Reset: state=IDLE, pc=0, instr=0, and all control outputs low (imem_en, instr_valid, vec_issue, busy, halted, err). rst mid-operation aborts any state immediately and discards pending vec_done.
- IDLE: outputs low. start=1 -> pc=0, go to FETCH.
- FETCH: imem_en=1, imem_addr=pc. Go to LATCH.
- LATCH: instr <= imem_rdata on this edge. Go to EXEC.
- EXEC: instr_valid=1 for exactly one cycle; decoder inputs are evaluated here (combinational from instr). Priority order:
  - dec_is_wfi -> HALT; pc unchanged.
  - !dec_is_not_vect -> vec_issue=1 this cycle, go to VWAIT.
  - dec_is_bne && bne_taken -> pc = pc + (sext(dec_branch_imm) >>> 1), arithmetic shift; go to FETCH.
  - otherwise -> pc = pc + 1, go to FETCH.
- VWAIT: instr is held, instr_valid=0. On vec_done=1 -> pc = pc + 1, go to FETCH. vec_done is ignored in every other state, including the EXEC cycle that issues.
- HALT: halted=1, pc and instr held. start=1 -> pc=0, go to FETCH.
- PC arithmetic is modulo 2^IMEM_AW, so wrap-around is silent. Branch offsets are word offsets: the byte offset {imm,0} divided by 4.
- Throughput: a scalar instruction takes 3 cycles. A vector instruction takes 3 cycles plus the vector latency.
- start while busy is ignored. start and rst together: rst wins.
- busy = state in {FETCH, LATCH, EXEC, VWAIT}.

Optional Feature:
- CGRA_ISSUE_TIMEOUT_EN defined: a counter clears on entry to VWAIT and increments each VWAIT cycle. Reaching TIMEOUT_CYCLES without vec_done sets err=1 (sticky until rst), forces HALT, and leaves pc pointing at the stalled instruction.
- Undefined: no counter is built, err is tied 0, and VWAIT waits indefinitely.

Test Plan:
- rst then start; imem holds [addi, addi, wfi] -> fetch addresses 0,1,2; instr_valid pulses in cycles 3, 6, 9 after start; halted=1 with pc=2.
- vmacc at addr 0, vec_done asserted 10 cycles after vec_issue -> one vec_issue pulse, busy stays high throughout, next fetch at addr 1 on the cycle after vec_done.
- BNE at addr 5 with imm=12'hFFC (-4) and bne_taken=1 -> next fetch at addr 3. Same case with bne_taken=0 -> next fetch at addr 6.
- pc=255 with IMEM_AW=8 executing addi -> next fetch at addr 0. Also pulse vec_done during EXEC of a vector instr -> ignored; controller remains in VWAIT.
- Assert rst while in VWAIT, then start -> all outputs return to reset values; fetch restarts at addr 0. start pulsed while busy -> no effect.
- With CGRA_ISSUE_TIMEOUT_EN and TIMEOUT_CYCLES=16, vec_done never asserted -> err=1 and halted=1 after 16 VWAIT cycles, pc unchanged. Without the macro, the controller stays in VWAIT and err stays 0.
